write_address_traversal: RTL and testbench

- Write-side counterpart of the SDRAM read-address walker.
- Generates the SDRAM write address (bank/row/column) for each logged data word and issues one write command per word to the SDRAM controller.
- Advances the address only after the controller confirms completion.
- Tracks buffer occupancy against read-side consumption so the read path never overtakes the write path and unread data is never overwritten.

---
 rtl/write_address_traversal.sv | 134 +++++++++++++
 tb/tb_write_address_traversal.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/write_address_traversal.sv
// Write-side SDRAM address walker: one write command per logged word, address
// advances on controller completion, fill level tracked against read consumption.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_IDLE      | waiting for WR_REQ while not FULL
// S_ISSUE     | WR_EN high for one cycle, timeout counter cleared
// S_WAIT_DONE | waiting for WR_DONE, timeout counter running
// S_ADVANCE   | WR_ACCEPT high for one cycle, address and fill step on exit
module write_address_traversal #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned FULL_LEVEL     = 16777216
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic        WR_REQ,
  input  logic        WR_DONE,
  input  logic        RD_NEXT,
  output logic [1:0]  BA_WRITE_OUT,
  output logic [8:0]  COL_WRITE_OUT,
  output logic [12:0] ROW_WRITE_OUT,
  output logic        WR_EN,
  output logic        WR_ACCEPT,
  output logic        FULL,
  output logic        EMPTY,
  output logic [24:0] FILL_COUNT,
  output logic [7:0]  WRAP_COUNT,
  output logic        ERR_TIMEOUT,
  output logic        ERR_UNDERFLOW
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);
  localparam logic [24:0]   FULL_LVL  = 25'(FULL_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_ADVANCE   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   wr_count_q, wr_count_d;
  logic [24:0]   fill_q, fill_d;
  logic [7:0]    wrap_q, wrap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_to_q, err_to_d;
  logic          err_uf_q, err_uf_d;
  logic          full, empty, fill_inc, fill_dec;

  assign full  = (fill_q >= FULL_LVL);
  assign empty = (fill_q == 25'd0);

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    wrap_d     = wrap_q;
    tmo_d      = tmo_q;
    err_to_d   = err_to_q;
    unique case (state_q)
      S_IDLE: begin
        if (WR_REQ && !full) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (WR_DONE) begin
          state_d = S_ADVANCE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
          // counter reaches TIMEOUT_CYCLES on this edge: reissue the same address
          if (tmo_q == TMO_LAST) begin
            err_to_d = 1'b1;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ADVANCE: begin
        state_d    = S_IDLE;
        wr_count_d = wr_count_q + 24'd1;
        if (wr_count_q == 24'hFF_FFFF && wrap_q != 8'hFF) wrap_d = wrap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Simultaneous commit and read leave the fill level unchanged.
  always_comb begin
    fill_inc = (state_q == S_ADVANCE);
    fill_dec = RD_NEXT && !empty;
    fill_d   = fill_q;
    err_uf_d = err_uf_q;
    if (RD_NEXT && empty) err_uf_d = 1'b1;
    if (fill_inc && !fill_dec)      fill_d = fill_q + 25'd1;
    else if (!fill_inc && fill_dec) fill_d = fill_q - 25'd1;
  end

  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      wr_count_q <= '0;
      fill_q     <= '0;
      wrap_q     <= '0;
      tmo_q      <= '0;
      err_to_q   <= 1'b0;
      err_uf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      fill_q     <= fill_d;
      wrap_q     <= wrap_d;
      tmo_q      <= tmo_d;
      err_to_q   <= err_to_d;
      err_uf_q   <= err_uf_d;
    end
  end

  assign BA_WRITE_OUT  = wr_count_q[23:22];
  assign COL_WRITE_OUT = wr_count_q[21:13];
  assign ROW_WRITE_OUT = wr_count_q[12:0];
  assign WR_EN         = (state_q == S_ISSUE);
  assign WR_ACCEPT     = (state_q == S_ADVANCE);
  assign FULL          = full;
  assign EMPTY         = empty;
  assign FILL_COUNT    = fill_q;
  assign WRAP_COUNT    = wrap_q;
  assign ERR_TIMEOUT   = err_to_q;
  assign ERR_UNDERFLOW = err_uf_q;

endmodule

// File: tb/tb_write_address_traversal.sv
// Randomized bench for write_address_traversal against a word-level model of
// address, fill level, wrap count and sticky errors.
module tb_write_address_traversal;

  localparam int unsigned TB_TMO  = 8;
  localparam int unsigned TB_FULL = 4;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        wr_req = 1'b0, wr_done = 1'b0, rd_next = 1'b0;
  logic [1:0]  ba;
  logic [8:0]  col;
  logic [12:0] row;
  logic        wr_en, wr_accept, full, empty, err_to, err_uf;
  logic [24:0] fill_count;
  logic [7:0]  wrap_count;

  always #5 clk = ~clk;

  write_address_traversal #(
    .TIMEOUT_CYCLES(TB_TMO),
    .FULL_LEVEL    (TB_FULL)
  ) dut (
    .CLK_48MHZ    (clk),
    .RESET        (rst_b),
    .WR_REQ       (wr_req),
    .WR_DONE      (wr_done),
    .RD_NEXT      (rd_next),
    .BA_WRITE_OUT (ba),
    .COL_WRITE_OUT(col),
    .ROW_WRITE_OUT(row),
    .WR_EN        (wr_en),
    .WR_ACCEPT    (wr_accept),
    .FULL         (full),
    .EMPTY        (empty),
    .FILL_COUNT   (fill_count),
    .WRAP_COUNT   (wrap_count),
    .ERR_TIMEOUT  (err_to),
    .ERR_UNDERFLOW(err_uf)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] m_addr;
  int          m_fill, m_wrap;
  bit          m_eto, m_euf;
  bit          cur_adv, e_en, e_acc, rd_rand;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_addr = '0; m_fill = 0; m_wrap = 0;
    m_eto = 1'b0; m_euf = 1'b0; cur_adv = 1'b0; e_en = 1'b0; e_acc = 1'b0;
  endtask

  task automatic check_all();
    chk_eq("ba",      32'(ba),         32'(m_addr[23:22]));
    chk_eq("col",     32'(col),        32'(m_addr[21:13]));
    chk_eq("row",     32'(row),        32'(m_addr[12:0]));
    chk_eq("fill",    32'(fill_count), 32'(m_fill));
    chk_eq("empty",   32'(empty),      32'(m_fill == 0));
    chk_eq("full",    32'(full),       32'(m_fill >= int'(TB_FULL)));
    chk_eq("wrap",    32'(wrap_count), 32'(m_wrap));
    chk_eq("err_to",  32'(err_to),     32'(m_eto));
    chk_eq("err_uf",  32'(err_uf),     32'(m_euf));
    chk_eq("wr_en",   32'(wr_en),      32'(e_en));
    chk_eq("wr_acc",  32'(wr_accept),  32'(e_acc));
  endtask

  // One clock: apply the word-level effects of the cycle ending at this edge.
  task automatic step();
    bit inc, dec;
    if (rd_rand && !rd_next) rd_next = ($urandom_range(0, 3) == 0);
    inc = cur_adv;
    dec = rd_next && (m_fill != 0);
    if (rd_next && m_fill == 0) m_euf = 1'b1;
    if (inc) begin
      if (m_addr == 24'hFF_FFFF && m_wrap < 255) m_wrap++;
      m_addr = m_addr + 24'd1;
    end
    m_fill = m_fill + (inc ? 1 : 0) - (dec ? 1 : 0);
    @(posedge clk);
    #1;
    cur_adv = e_acc;
    rd_next = 1'b0;
    wr_done = 1'b0;
    check_all();
    e_en  = 1'b0;
    e_acc = 1'b0;
  endtask

  // Caller guarantees the fill level is below FULL when this is entered.
  task automatic do_write(input int d, input bit tmo);
    wr_req = 1'b1;
    e_en = 1'b1; step();                       // ISSUE
    wr_done = ($urandom_range(0, 1) == 1);     // ignored outside WAIT_DONE
    step();                                    // WAIT_DONE cycle 1
    if (tmo) begin
      repeat (TB_TMO - 1) step();
      m_eto = 1'b1;
      e_en = 1'b1; step();                     // reissue, same address
      step();
    end
    repeat (d) step();
    wr_done = 1'b1;
    e_acc = 1'b1; step();                      // ADVANCE
    wr_req = 1'b0;
    step();                                    // IDLE, new address
  endtask

  initial begin
    model_reset();
    rd_rand = 1'b0;
    #12;
    check_all();
    rst_b = 1'b1;
    repeat (3) step();

    // three words, WR_DONE three cycles after WR_EN
    repeat (3) do_write(2, 1'b0);

    // back-pressure at the lowered FULL level
    do_write(1, 1'b0);
    wr_req = 1'b1;
    repeat (3) step();
    rd_next = 1'b1; step();
    e_en = 1'b1; step();
    step();
    wr_done = 1'b1; e_acc = 1'b1; step();
    rd_next = 1'b1; wr_req = 1'b0; step();      // read coincident with commit
    step();

    // timeout and retry of the same address
    repeat (3) begin rd_next = 1'b1; step(); end
    do_write(1, 1'b1);

    // underflow
    rd_next = 1'b1; step();
    rd_next = 1'b1; step();
    step();

    // address wrap
    force dut.wr_count_q = 24'hFF_FFFF;
    m_addr = 24'hFF_FFFF;
    step();
    release dut.wr_count_q;
    step();
    do_write(0, 1'b0);
    do_write(1, 1'b0);

    // randomized traffic with random reads
    rd_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0 || m_fill >= int'(TB_FULL)) begin
        wr_done = ($urandom_range(0, 1) == 1);
        step();
      end else begin
        do_write(int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0));
      end
    end
    rd_rand = 1'b0;
    step();

    // reset during WAIT_DONE
    while (m_fill >= int'(TB_FULL)) begin rd_next = 1'b1; step(); end
    wr_req = 1'b1;
    e_en = 1'b1; step();
    step();
    #2;
    rst_b = 1'b0;
    model_reset();
    #1;
    check_all();
    wr_req = 1'b0;
    wr_done = 1'b1;
    #10;
    rst_b = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
